// File: rtl/wb_master_engine.sv
// Wishbone classic-cycle master: one valid/ready command in, one response pulse out.
// Optional bus timeout is compiled in with `define WB_MASTER_TIMEOUT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | ready for a command, bus outputs parked at 0
// ST_BUS  | cycle in flight, waiting for ack/err (or timeout)
// ST_RESP | one-cycle response pulse, then back to idle
module wb_master_engine #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = DATA_W / 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              cmd_valid_in,
    output logic              cmd_ready_o,
    input  logic              cmd_we_in,
    input  logic [ADDR_W-1:0] cmd_adr_in,
    input  logic [DATA_W-1:0] cmd_dat_in,
    input  logic [SEL_W-1:0]  cmd_sel_in,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_dat_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [DATA_W-1:0] dat_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic              we_o,
    output logic              cyc_o,
    output logic              stb_o,
    input  logic [DATA_W-1:0] dat_in,
    input  logic              ack_in,
    input  logic              err_in
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic                cyc_q, cyc_d;
    logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic                rsp_err_q, rsp_err_d;
    logic                bus_end;

`ifdef WB_MASTER_TIMEOUT_EN
    logic [7:0]          cnt_q, cnt_d;
    logic                rsp_to_q, rsp_to_d;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q     <= 8'd0;
            rsp_to_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q     <= cnt_d;
            rsp_to_q  <= rsp_to_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        rsp_dat_d = rsp_dat_q;
        // Response flags are only ever set on the edge into ST_RESP, so they
        // read back as 0 everywhere else.
        rsp_err_d = 1'b0;
        bus_end   = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        cnt_d     = cnt_q;
        rsp_to_d  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_in) begin
                    adr_d   = cmd_adr_in;
                    dat_d   = cmd_dat_in;
                    sel_d   = cmd_sel_in;
                    we_d    = cmd_we_in;
                    cyc_d   = 1'b1;
                    state_d = ST_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            ST_BUS: begin
                if (err_in) begin
                    bus_end   = 1'b1;
                    rsp_err_d = 1'b1;
                end else if (ack_in) begin
                    bus_end = 1'b1;
                    if (!we_q) begin
                        rsp_dat_d = dat_in;
                    end
                end
`ifdef WB_MASTER_TIMEOUT_EN
                // Count reaches TIMEOUT on this edge: cnt_q still holds TIMEOUT-1.
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    bus_end   = 1'b1;
                    rsp_err_d = 1'b1;
                    rsp_to_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
                if (bus_end) begin
                    adr_d   = '0;
                    dat_d   = '0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    cyc_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign sel_o       = sel_q;
    assign we_o        = we_q;
    assign cyc_o       = cyc_q;
    assign stb_o       = cyc_q;

`ifdef WB_MASTER_TIMEOUT_EN
    assign rsp_timeout_o = rsp_to_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine: write, waited read, ack+err, timeout/no-timeout,
// and reset mid-cycle. Honors WB_MASTER_TIMEOUT_EN when the design is built with it.
module tb_wb_master_engine;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cmd_valid_in;
    logic        cmd_ready_o;
    logic        cmd_we_in;
    logic [4:0]  cmd_adr_in;
    logic [31:0] cmd_dat_in;
    logic [3:0]  cmd_sel_in;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic [4:0]  adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic [31:0] dat_in;
    logic        ack_in;
    logic        err_in;

    int checks = 0;
    int errors = 0;
    int cyc_cnt;

    wb_master_engine #(.ADDR_W(5), .DATA_W(32), .SEL_W(4), .TIMEOUT(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_o(cmd_ready_o),
        .cmd_we_in(cmd_we_in), .cmd_adr_in(cmd_adr_in),
        .cmd_dat_in(cmd_dat_in), .cmd_sel_in(cmd_sel_in),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
        .cyc_o(cyc_o), .stb_o(stb_o),
        .dat_in(dat_in), .ack_in(ack_in), .err_in(err_in)
    );

    always #5 clk_in = ~clk_in;

    // Advance past the next rising edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        cmd_valid_in = 1'b1;
        cmd_we_in    = we;
        cmd_adr_in   = adr;
        cmd_dat_in   = dat;
        cmd_sel_in   = sel;
        tick();
        cmd_valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b1; cmd_valid_in = 1'b0; cmd_we_in = 1'b0; cmd_adr_in = '0;
        cmd_dat_in = '0; cmd_sel_in = '0; dat_in = '0; ack_in = 1'b0; err_in = 1'b0;
        tick(); tick();
        rst_in = 1'b0;

        // reset / idle
        chk("rst_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_cyc", 32'(cyc_o), 32'd0);
        chk("rst_stb", 32'(stb_o), 32'd0);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_adr", 32'(adr_o), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_dat", rsp_dat_o, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_rsp_to", 32'(rsp_timeout_o), 32'd0);

        // ack while idle is ignored
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        chk("idle_ack_rsp", 32'(rsp_valid_o), 32'd0);
        chk("idle_ack_cyc", 32'(cyc_o), 32'd0);

        // zero-wait write
        issue(1'b1, 5'h04, 32'hDEADBEEF, 4'hF);
        chk("wr_cyc", 32'(cyc_o), 32'd1);
        chk("wr_stb", 32'(stb_o), 32'd1);
        chk("wr_we", 32'(we_o), 32'd1);
        chk("wr_adr", 32'(adr_o), 32'h04);
        chk("wr_dat", dat_o, 32'hDEADBEEF);
        chk("wr_sel", 32'(sel_o), 32'hF);
        chk("wr_busy", 32'(cmd_ready_o), 32'd0);
        chk("wr_norsp", 32'(rsp_valid_o), 32'd0);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        chk("wr_cyc_fall", 32'(cyc_o), 32'd0);
        chk("wr_adr_clr", 32'(adr_o), 32'd0);
        chk("wr_dat_clr", dat_o, 32'd0);
        chk("wr_we_clr", 32'(we_o), 32'd0);
        chk("wr_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("wr_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("wr_rsp_to", 32'(rsp_timeout_o), 32'd0);
        tick();
        chk("wr_ready_again", 32'(cmd_ready_o), 32'd1);
        chk("wr_rsp_pulse", 32'(rsp_valid_o), 32'd0);

        // read with 3 wait states; a competing command during BUS must be ignored
        issue(1'b0, 5'h08, 32'h0, 4'hF);
        cmd_valid_in = 1'b1; cmd_adr_in = 5'h1F; cmd_we_in = 1'b1;
        cyc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (stb_o === 1'b1) cyc_cnt++;
            chk("rd_adr_hold", 32'(adr_o), 32'h08);
            chk("rd_we", 32'(we_o), 32'd0);
            if (i == 3) begin
                ack_in = 1'b1; dat_in = 32'h12345678; cmd_valid_in = 1'b0;
            end
            tick();
        end
        ack_in = 1'b0; dat_in = 32'h0;
        chk("rd_stb_cycles", 32'(cyc_cnt), 32'd4);
        chk("rd_stb_fall", 32'(stb_o), 32'd0);
        chk("rd_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("rd_rsp_dat", rsp_dat_o, 32'h12345678);
        chk("rd_rsp_err", 32'(rsp_err_o), 32'd0);
        tick();

        // following write leaves read data alone
        issue(1'b1, 5'h01, 32'h000000A5, 4'h1);
        ack_in = 1'b1; dat_in = 32'hCAFEF00D;
        tick();
        ack_in = 1'b0; dat_in = 32'h0;
        chk("wr2_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("wr2_rsp_dat_keep", rsp_dat_o, 32'h12345678);
        tick();

        // read terminated by ack and err together: err wins, no capture
        issue(1'b0, 5'h02, 32'h0, 4'hF);
        ack_in = 1'b1; err_in = 1'b1; dat_in = 32'hFFFFFFFF;
        tick();
        ack_in = 1'b0; err_in = 1'b0; dat_in = 32'h0;
        chk("ae_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("ae_rsp_err", 32'(rsp_err_o), 32'd1);
        chk("ae_rsp_to", 32'(rsp_timeout_o), 32'd0);
        chk("ae_rsp_dat_keep", rsp_dat_o, 32'h12345678);
        tick();
        chk("ae_err_cleared", 32'(rsp_err_o), 32'd0);
        chk("ae_ready", 32'(cmd_ready_o), 32'd1);

        // silent slave
        issue(1'b0, 5'h10, 32'h0, 4'hF);
`ifdef WB_MASTER_TIMEOUT_EN
        cyc_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (cyc_o === 1'b1) cyc_cnt++;
            tick();
        end
        chk("to_cyc_cycles", 32'(cyc_cnt), 32'd16);
        chk("to_cyc_fall", 32'(cyc_o), 32'd0);
        chk("to_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("to_rsp_err", 32'(rsp_err_o), 32'd1);
        chk("to_rsp_to", 32'(rsp_timeout_o), 32'd1);
        chk("to_rsp_dat_keep", rsp_dat_o, 32'h12345678);
        tick();
        chk("to_flag_cleared", 32'(rsp_timeout_o), 32'd0);
`else
        cyc_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (cyc_o === 1'b1 && rsp_valid_o === 1'b0) cyc_cnt++;
            tick();
        end
        chk("noto_cyc_cycles", 32'(cyc_cnt), 32'd100);
        chk("noto_still_busy", 32'(cyc_o), 32'd1);
        ack_in = 1'b1; dat_in = 32'h0BADF00D;
        tick();
        ack_in = 1'b0; dat_in = 32'h0;
        chk("noto_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("noto_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("noto_rsp_to", 32'(rsp_timeout_o), 32'd0);
        chk("noto_rsp_dat", rsp_dat_o, 32'h0BADF00D);
        tick();
`endif

        // reset in the second BUS cycle
        issue(1'b1, 5'h03, 32'h55AA55AA, 4'h3);
        chk("rb_cyc1", 32'(cyc_o), 32'd1);
        tick();
        chk("rb_cyc2", 32'(cyc_o), 32'd1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("rb_cyc_drop", 32'(cyc_o), 32'd0);
        chk("rb_stb_drop", 32'(stb_o), 32'd0);
        chk("rb_ready", 32'(cmd_ready_o), 32'd1);
        chk("rb_no_rsp", 32'(rsp_valid_o), 32'd0);
        chk("rb_rsp_dat_clr", rsp_dat_o, 32'd0);
        tick();
        chk("rb_no_rsp_later", 32'(rsp_valid_o), 32'd0);
        chk("rb_idle_cyc", 32'(cyc_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_master_engine.md
# wb_master_engine

Parametrised, synthesizable Wishbone classic-cycle master driven by a valid/ready command port and returning one response per command. It replaces testbench-task-driven bus stimulus in the SPI subsystem with an RTL engine that firmware or a test sequencer can drive. It supports reads and writes, configurable address and data widths, byte selects, error termination and an optional bus timeout.

## Interface

Parameters:
- `ADDR_W`, default 5: Wishbone address width.
- `DATA_W`, default 32: data width; must be a multiple of 8.
- `SEL_W`, default `DATA_W/8`: byte-select width.
- `TIMEOUT`, default 16: cycles before abort, range 1..255. Used only with `WB_MASTER_TIMEOUT_EN`.

Ports:
- `clk_in` in 1: single clock. All logic is on the rising edge.
- `rst_in` in 1: synchronous, active-high reset.
- `cmd_valid_in` in 1: command present.
- `cmd_ready_o` out 1: engine can accept a command.
- `cmd_we_in` in 1: 1 = write, 0 = read.
- `cmd_adr_in` in ADDR_W: command address.
- `cmd_dat_in` in DATA_W: write data.
- `cmd_sel_in` in SEL_W: byte selects.
- `rsp_valid_o` out 1: one-cycle response pulse.
- `rsp_dat_o` out DATA_W: read data.
- `rsp_err_o` out 1: the cycle ended by `err_in` or by timeout.
- `rsp_timeout_o` out 1: the cycle ended by timeout.
- `adr_o` out ADDR_W, `dat_o` out DATA_W, `sel_o` out SEL_W, `we_o` out 1, `cyc_o` out 1, `stb_o` out 1: Wishbone master outputs. All are registered.
- `dat_in` in DATA_W, `ack_in` in 1, `err_in` in 1: Wishbone slave returns.

## Operation

- FSM states: IDLE, BUS, RESP. Reset enters IDLE.
- **IDLE**
  - `cmd_ready_o`=1.
  - On `cmd_valid_in && cmd_ready_o`, register the command onto `adr_o`/`dat_o`/`sel_o`/`we_o`, set `cyc_o`=`stb_o`=1, and go to BUS.
- **BUS**
  - `cmd_ready_o`=0.
  - Bus outputs hold steady until termination.
  - On an edge where `ack_in` or `err_in` is sampled high, clear `cyc_o` and `stb_o`, drive `adr_o`/`dat_o`/`sel_o`/`we_o` to 0, and go to RESP.
  - If `ack_in` and `err_in` are high together, `err_in` wins: `rsp_err_o`=1 and read data is not captured.
  - On a read with ack, `rsp_dat_o` captures `dat_in` on that edge.
- **RESP**
  - `rsp_valid_o`=1 for exactly one cycle, then go to IDLE.
  - `rsp_err_o`/`rsp_timeout_o` are valid only while `rsp_valid_o`=1; they are 0 otherwise.
  - `rsp_dat_o` holds its value until the next successful read, so a write or error response leaves it unchanged.
- There is no response backpressure. The consumer must take `rsp_valid_o` when it pulses.
- Command inputs are ignored outside IDLE.
- The engine never drives high-impedance. Idle bus outputs are 0.

## Timing

- Reset value of every output: 0, except `cmd_ready_o`=1 (it is decoded from IDLE).
- Accept at edge N:
  - `cyc_o`/`stb_o` are high from N+1.
  - With a zero-wait slave (ack high in cycle N+1), `cyc_o`/`stb_o` fall at N+2 and `rsp_valid_o` is high during N+2.
  - `cmd_ready_o` is high again at N+3.
- Minimum throughput: 1 transaction per 3 cycles. Each wait state adds 1 cycle.
- `rst_in` during BUS or RESP:
  - `cyc_o`/`stb_o` drop at the next edge.
  - The transaction is discarded and no response is issued.
  - `rsp_dat_o` clears to 0.
- `ack_in`/`err_in` are ignored in IDLE and RESP.

## Configuration

- Macro: `WB_MASTER_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter clears on entry to BUS and increments each BUS cycle without ack/err.
  - When the count equals `TIMEOUT` with no ack/err on that edge, the engine terminates exactly as for `err_in`, with `rsp_err_o`=1 and `rsp_timeout_o`=1.
  - Ack on the same edge the count reaches `TIMEOUT` counts as a normal completion.
- **Undefined:**
  - There is no counter, and BUS waits indefinitely.
  - `rsp_timeout_o` is tied to 0.

## Test plan

- Reset, then idle. Response: all outputs 0 and `cmd_ready_o`=1.
- Write `adr`=5'h04, `dat`=32'hDEADBEEF, `sel`=4'hF; slave acks immediately. Response: `cyc_o`/`stb_o`/`we_o`=1 for exactly 1 cycle with those values on the bus, then `rsp_valid_o`=1 with `rsp_err_o`=0.
- Read `adr`=5'h08; slave inserts 3 wait states and returns 32'h12345678. Response: `stb_o` high for 4 cycles, then `rsp_valid_o`=1 with `rsp_dat_o`=32'h12345678. A following write leaves `rsp_dat_o` at 32'h12345678.
- Read with `ack_in` and `err_in` asserted together. Response: `rsp_err_o`=1, `rsp_timeout_o`=0, and `rsp_dat_o` unchanged.
- `WB_MASTER_TIMEOUT_EN` defined, `TIMEOUT`=16, slave never responds. Response: abort after 16 BUS cycles with `rsp_err_o`=1 and `rsp_timeout_o`=1. Without the macro, `cyc_o` stays high through 100 cycles.
- `rst_in` pulsed in the 2nd BUS cycle. Response: `cyc_o`/`stb_o`=0 at the next edge, no `rsp_valid_o`, and `cmd_ready_o`=1.
